cdr_lock_controller: RTL
========================

# cdr_lock_controller

Digital loop controller for the clock-recovery path. It integrates the phase detector's `up`/`down` pulses over fixed windows and steers the digitally controlled oscillator's control word. It sequences coarse acquisition, fine tracking and lock detection, and reports lock status to the receiver. It sits between `phase_detector` and the VCO/DCO model in the recovery loop.

## Interface
Parameters:
- `CTRL_W`, 8: width of the oscillator control word.
- `CTRL_INIT`, 128: control word value after reset.
- `WIN`, 16: evaluation window length in cycles; power of two, ≥4.
- `BAL_TH`, 2: a window is balanced when |net| ≤ `BAL_TH`.
- `COARSE_STEP`, 4: ctrl step size in ACQUIRE.
- `LOCK_WINS`, 4: consecutive balanced windows in TRACK required to declare lock.
- `LOSS_WINS`, 2: consecutive unbalanced windows in LOCKED required to declare loss.

Ports:
- `clock` in 1: single clock. Every register updates on its rising edge.
- `reset_L` in 1: synchronous, active-low reset.
- `enable` in 1: loop enable.
- `up` in 1: phase detector "oscillator slow", already synchronous to `clock`.
- `down` in 1: phase detector "oscillator fast", already synchronous to `clock`.
- `ctrl` out `CTRL_W`: oscillator control word. A larger value means a faster oscillator.
- `state` out 2: IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3.
- `locked` out 1: high while state is LOCKED.
- `lock_lost` out 1: one-cycle pulse on the LOCKED→ACQUIRE transition.

## Operation
- Per-cycle contribution: up only → +1; down only → −1; both high or both low → 0.
- `net` is a signed accumulator of width clog2(`WIN`)+2. It cannot overflow within one window.
- `wcnt` counts 0..`WIN`−1 while state ≠ IDLE.
- Window end: the edge where `wcnt`=`WIN`−1.
  - Evaluate `netf` = `net` + this cycle's contribution.
  - Clear `net` and `wcnt`.
  - Update `ctrl`, `state` and `bcnt` (the balanced/unbalanced run counter) on that same edge.
- ctrl update at window end, only if the window is unbalanced:
  - Step size is `COARSE_STEP` in ACQUIRE and 1 in TRACK/LOCKED.
  - Add the step if `netf` > 0; subtract it if `netf` < 0.
  - Saturate to [0, 2^`CTRL_W`−1]; ctrl never wraps.
  - ctrl is never changed in IDLE.
- State transitions (evaluated only at window end, except the IDLE rules):
  - IDLE→ACQUIRE: on the first edge with `enable`=1. `net`, `wcnt` and `bcnt` start at 0.
  - ACQUIRE: a balanced window increments `bcnt`; an unbalanced window clears it. At 2 → TRACK, `bcnt`=0.
  - TRACK: same counting. At `LOCK_WINS` → LOCKED, `bcnt`=0.
  - LOCKED: `bcnt` counts consecutive unbalanced windows and is cleared by a balanced window. At `LOSS_WINS` → ACQUIRE, `lock_lost`=1 for that one cycle, `bcnt`=0.
  - Any state with `enable`=0 → IDLE on the next edge. `net`, `wcnt` and `bcnt` clear; ctrl holds its value. This takes priority over a coincident window end: no ctrl update happens on that edge.
- Reset (`reset_L`=0 at an edge), including mid-window or in any state:
  - ctrl=`CTRL_INIT`, state=IDLE, `locked`=0, `lock_lost`=0.
  - `net`, `wcnt` and `bcnt` all clear.
  - Reset overrides `enable`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `up`/`down` sampled on edge k affect ctrl at the window-end edge at the latest, i.e. at most `WIN` cycles later.
- First possible ctrl change: `WIN` edges after the IDLE→ACQUIRE edge.
- Fastest lock from enable: 1 + `WIN`·(2 + `LOCK_WINS`) edges, i.e. 97 with the default parameters.
- `locked` and `state` change on the same edge.
- `lock_lost` is high only in the cycle after the transition edge, and is never asserted on reset or on entry to IDLE.

## Structure
- A shared package `cdr_pkg` holds:
  - the `state` encoding constants (IDLE/ACQUIRE/TRACK/LOCKED);
  - the contribution encoding, +1/0/−1.
- One natural sub-module, `cdr_window_integrator`, contains `net`, `wcnt`, the window-end strobe, `netf` and the balanced flag.
- The FSM, `bcnt` and the ctrl saturation logic stay in the top module.

## Test plan
- Reset and idle: hold `reset_L`=0 for 3 cycles, then `enable`=0 for 50 cycles → ctrl=128, state=0, `locked`=0 and `lock_lost`=0 throughout.
- Coarse acquire: enable with `up`=1 and `down`=0 constantly → ctrl reads 132 after edge 17, then 136, 140, … every 16 cycles, and state stays 1.
- Saturation: `CTRL_INIT`=253 with constant `up` → ctrl goes 253→255 and holds at 255. Mirror case: `CTRL_INIT`=2 with constant `down` → ctrl goes to 0 and holds.
- Lock sequence: enable with `up`=`down`=0 → state becomes 2 after window 2 and 3 at edge 97, `locked`=1, and ctrl stays 128. A window with `netf`=2 counts as balanced; a window with `netf`=3 clears the run counter.
- Loss of lock: from LOCKED, drive constant `down` for 2 windows → ctrl steps −1 per window (128→127→126), `lock_lost` pulses for exactly one cycle, and state returns to 1.
- Boundary cases:
  - Deassert `enable` on the window-end edge → ctrl unchanged, state=0 next cycle.
  - Pulse `reset_L`=0 mid-window while LOCKED → all outputs return to their reset values on that edge.
  - Drive `up`=`down`=1 for a full window → treated as balanced.

Source files
------------

// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared state and phase-contribution encodings for the CDR lock controller
package cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } cdr_state_t;

    // Per-cycle phase detector contribution to the window accumulator
    localparam logic signed [1:0] CONTRIB_UP   = 2'sb01;
    localparam logic signed [1:0] CONTRIB_NONE = 2'sb00;
    localparam logic signed [1:0] CONTRIB_DOWN = 2'sb11;

    // Balanced windows needed in ACQUIRE before moving on to fine tracking
    localparam int ACQ_WINS = 2;

    // up alone speeds the oscillator up, down alone slows it; both or neither cancel
    function automatic logic signed [1:0] contribution(input logic up_i, input logic down_i);
        logic signed [1:0] c;
        c = CONTRIB_NONE;
        if (up_i && !down_i) begin
            c = CONTRIB_UP;
        end else if (down_i && !up_i) begin
            c = CONTRIB_DOWN;
        end
        return c;
    endfunction

endpackage

// File: rtl/cdr_window_integrator.sv
// rtl/cdr_window_integrator.sv - integrates up/down over fixed windows and flags balanced windows
module cdr_window_integrator
    import cdr_pkg::*;
#(
    parameter  int WIN    = 16,
    parameter  int BAL_TH = 2,
    localparam int NET_W  = $clog2(WIN) + 2,
    localparam int CNT_W  = $clog2(WIN)
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic                    active_i,
    input  logic                    up_i,
    input  logic                    down_i,
    output logic                    win_end_o,
    output logic signed [NET_W-1:0] netf_o,
    output logic                    balanced_o
);

    localparam logic [CNT_W-1:0]        WCNT_LAST = CNT_W'(WIN - 1);
    localparam logic signed [NET_W-1:0] TH_POS    = NET_W'(BAL_TH);
    localparam logic signed [NET_W-1:0] TH_NEG    = -TH_POS;

    logic signed [NET_W-1:0] net_q, net_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic signed [1:0]       contrib;
    logic signed [NET_W-1:0] contrib_ext;

    assign contrib     = contribution(up_i, down_i);
    assign contrib_ext = {{(NET_W-2){contrib[1]}}, contrib};

    // The final sample of a window is folded in before the window is judged
    assign netf_o     = net_q + contrib_ext;
    assign win_end_o  = active_i && (wcnt_q == WCNT_LAST);
    assign balanced_o = (netf_o <= TH_POS) && (netf_o >= TH_NEG);

    // Accumulate while running; restart at each window end and whenever the loop is idle
    always_comb begin
        net_d  = net_q;
        wcnt_d = wcnt_q;
        if (!active_i || win_end_o) begin
            net_d  = '0;
            wcnt_d = '0;
        end else begin
            net_d  = netf_o;
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    // Accumulator and window counter registers
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            net_q  <= '0;
            wcnt_q <= '0;
        end else begin
            net_q  <= net_d;
            wcnt_q <= wcnt_d;
        end
    end

endmodule

// File: rtl/cdr_lock_controller.sv
// rtl/cdr_lock_controller.sv - CDR loop controller: acquire/track/lock sequencing and DCO word steering
module cdr_lock_controller
    import cdr_pkg::*;
#(
    parameter int CTRL_W      = 8,
    parameter int CTRL_INIT   = 128,
    parameter int WIN         = 16,
    parameter int BAL_TH      = 2,
    parameter int COARSE_STEP = 4,
    parameter int LOCK_WINS   = 4,
    parameter int LOSS_WINS   = 2
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    output logic [CTRL_W-1:0] ctrl,
    output logic [1:0]        state,
    output logic              locked,
    output logic              lock_lost
);

    localparam int NET_W    = $clog2(WIN) + 2;
    localparam int BMAX_A   = (ACQ_WINS > LOCK_WINS) ? ACQ_WINS : LOCK_WINS;
    localparam int BCNT_MAX = (BMAX_A > LOSS_WINS) ? BMAX_A : LOSS_WINS;
    localparam int BCNT_W   = $clog2(BCNT_MAX + 1);

    localparam logic [CTRL_W+1:0] CTRL_MAX    = {2'b00, {CTRL_W{1'b1}}};
    localparam logic [CTRL_W+1:0] STEP_COARSE = (CTRL_W+2)'(COARSE_STEP);
    localparam logic [CTRL_W+1:0] STEP_FINE   = (CTRL_W+2)'(1);
    localparam logic [BCNT_W-1:0] ACQ_TARGET  = BCNT_W'(ACQ_WINS);
    localparam logic [BCNT_W-1:0] LOCK_TARGET = BCNT_W'(LOCK_WINS);
    localparam logic [BCNT_W-1:0] LOSS_TARGET = BCNT_W'(LOSS_WINS);

    cdr_state_t          state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                locked_q, locked_d;
    logic                lock_lost_q, lock_lost_d;

    logic                    active;
    logic                    win_end;
    logic signed [NET_W-1:0] netf;
    logic                    balanced;
    logic [BCNT_W-1:0]       bcnt_inc;
    logic [CTRL_W+1:0]       step;
    logic [CTRL_W+1:0]       ctrl_wide;
    logic [CTRL_W+1:0]       ctrl_sum;
    logic [CTRL_W-1:0]       ctrl_stepped;

    // Integration only runs when enabled and out of IDLE, so an enable drop pre-empts a window end
    assign active = enable && (state_q != ST_IDLE);

    cdr_window_integrator #(
        .WIN    (WIN),
        .BAL_TH (BAL_TH)
    ) u_integrator (
        .clock      (clock),
        .reset_L    (reset_L),
        .active_i   (active),
        .up_i       (up),
        .down_i     (down),
        .win_end_o  (win_end),
        .netf_o     (netf),
        .balanced_o (balanced)
    );

    assign bcnt_inc = bcnt_q + 1'b1;

    // Saturating control-word step: coarse while acquiring, single LSB once tracking
    always_comb begin
        step         = (state_q == ST_ACQUIRE) ? STEP_COARSE : STEP_FINE;
        ctrl_wide    = {2'b00, ctrl_q};
        ctrl_sum     = ctrl_wide + step;
        ctrl_stepped = ctrl_q;
        if (netf > 0) begin
            ctrl_stepped = (ctrl_sum > CTRL_MAX) ? CTRL_MAX[CTRL_W-1:0] : ctrl_sum[CTRL_W-1:0];
        end else if (netf < 0) begin
            ctrl_stepped = (ctrl_wide < step) ? '0 : ctrl_q - step[CTRL_W-1:0];
        end
    end

    // Next-state logic: enable drop wins, otherwise state moves only at window ends
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        bcnt_d      = bcnt_q;
        lock_lost_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
        end else begin
            if (win_end && !balanced) begin
                ctrl_d = ctrl_stepped;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    bcnt_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (win_end) begin
                        if (!balanced) begin
                            bcnt_d = '0;
                        end else if (bcnt_inc == ACQ_TARGET) begin
                            state_d = ST_TRACK;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_inc;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_end) begin
                        if (!balanced) begin
                            bcnt_d = '0;
                        end else if (bcnt_inc == LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Here the run counter tracks consecutive unbalanced windows
                    if (win_end) begin
                        if (balanced) begin
                            bcnt_d = '0;
                        end else if (bcnt_inc == LOSS_TARGET) begin
                            state_d     = ST_ACQUIRE;
                            bcnt_d      = '0;
                            lock_lost_d = 1'b1;
                        end else begin
                            bcnt_d = bcnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bcnt_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Controller state registers; reset overrides enable
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= CTRL_W'(CTRL_INIT);
            bcnt_q      <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            bcnt_q      <= bcnt_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign state     = state_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;

endmodule
